// File: rtl/jb_prach_sched_pkg.sv
// Shared types for the PRACH occasion scheduler.
// Holds the FSM state encoding and the occasion config bundle.
package jb_prach_sched_pkg;

  localparam int CNT_W_DEF = 20;
  localparam int OCC_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    OFFSET,
    OCC
  } state_e;

  typedef struct packed {
    logic [3:0]           format;
    logic [9:0]           prach_cp;
    logic [CNT_W_DEF-1:0] wait_time;
    logic [CNT_W_DEF-1:0] offset;
    logic [CNT_W_DEF-1:0] period;
    logic [OCC_W_DEF-1:0] num_occ;
  } cfg_t;

endpackage

// File: rtl/jb_prach_cfg_shadow.sv
// Config shadow register: valid/ready capture, applied atomically.
// A transfer coinciding with apply bypasses the shadow straight to active.
module jb_prach_cfg_shadow
  import jb_prach_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clk_en,
  input  logic                 cfg_valid_i,
  input  cfg_t                 cfg_i,
  input  logic                 apply_i,
  output logic                 cfg_ready_o,
  output logic                 applied_o,
  output cfg_t                 act_o,
  output logic [CNT_W_DEF-1:0] eff_off_o,
  output logic [OCC_W_DEF-1:0] eff_num_o
);

  cfg_t shadow_q;
  cfg_t act_q;
  cfg_t src;
  logic full_q;
  logic applied_q;
  logic xfer;
  logic do_apply;

  assign xfer     = clk_en & cfg_valid_i & ~full_q;
  assign do_apply = apply_i & (full_q | xfer);
  assign src      = full_q ? shadow_q : cfg_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q  <= '0;
      act_q     <= '0;
      full_q    <= 1'b0;
      applied_q <= 1'b0;
    end else if (clk_en) begin
      applied_q <= do_apply;
      if (do_apply) begin
        act_q  <= src;
        full_q <= 1'b0;
      end else if (xfer) begin
        shadow_q <= cfg_i;
        full_q   <= 1'b1;
      end
    end
  end

  // Frame start must see the config it is about to apply
  assign eff_off_o   = do_apply ? src.offset : act_q.offset;
  assign eff_num_o   = do_apply ? src.num_occ : act_q.num_occ;
  assign cfg_ready_o = ~full_q;
  assign applied_o   = applied_q;
  assign act_o       = act_q;

endmodule

// File: rtl/jb_prach_occasion_sched.sv
// PRACH occasion scheduler: frame-aligned config apply and
// sub_frame_mrkr generation over qualified samples.
module jb_prach_occasion_sched
  import jb_prach_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int OCC_W = OCC_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clk_en,
  input  logic             dv,
  input  logic             frame_mrkr,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [3:0]       cfg_format,
  input  logic [9:0]       cfg_prach_cp,
  input  logic [CNT_W-1:0] cfg_wait_time,
  input  logic [CNT_W-1:0] cfg_offset,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [OCC_W-1:0] cfg_num_occ,
  output logic [3:0]       format,
  output logic [9:0]       prach_cp,
  output logic [CNT_W-1:0] wait_time,
  output logic             sub_frame_mrkr,
  output logic             occ_active,
  output logic [OCC_W-1:0] occ_idx,
  output logic             cfg_applied,
  output logic             frame_overrun
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, per_m1;
  logic [OCC_W-1:0] idx_q, idx_d, num_m1;
  logic             sfm_q, sfm_d;
  logic             act_q, act_d;
  logic             ovr_q, ovr_d;
  logic             qs, fm, expiry, last, off_hit;
  cfg_t             cfg_in, act_cfg;
  logic [CNT_W-1:0] eff_off;
  logic [OCC_W-1:0] eff_num;

  assign cfg_in = '{cfg_format, cfg_prach_cp, cfg_wait_time,
                    cfg_offset, cfg_period, cfg_num_occ};

  jb_prach_cfg_shadow u_shadow (
    .clk         (clk),
    .reset_n     (reset_n),
    .clk_en      (clk_en),
    .cfg_valid_i (cfg_valid),
    .cfg_i       (cfg_in),
    .apply_i     (fm),
    .cfg_ready_o (cfg_ready),
    .applied_o   (cfg_applied),
    .act_o       (act_cfg),
    .eff_off_o   (eff_off),
    .eff_num_o   (eff_num)
  );

  assign qs      = clk_en & dv;
  assign fm      = qs & frame_mrkr;
  assign cnt_inc = cnt_q + 1'b1;
  // A zero period behaves as one sample per occasion
  assign per_m1  = (act_cfg.period == '0) ? '0 : act_cfg.period - 1'b1;
  assign num_m1  = act_cfg.num_occ - 1'b1;
  assign expiry  = (state_q == OCC) && (cnt_q == per_m1);
  assign last    = expiry && (idx_q == num_m1);
  assign off_hit = (state_q == OFFSET) && (cnt_inc == act_cfg.offset);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sfm_q   <= 1'b0;
      act_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (clk_en) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sfm_q   <= sfm_d;
      act_q   <= act_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (fm) begin
      if (eff_num == '0)
        state_d = (state_q == IDLE) ? IDLE : ARMED;
      else if (eff_off == '0)
        state_d = OCC;
      else
        state_d = OFFSET;
    end else begin
      case (state_q)
        IDLE:
          if (!cfg_ready || act_cfg.num_occ != '0) state_d = ARMED;
        OFFSET:
          if (qs && off_hit) state_d = OCC;
        OCC:
          if (qs && last) state_d = ARMED;
        default: ;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    sfm_d = 1'b0;
    act_d = act_q;
    // Final expiry colliding with a marker is a clean frame, not overrun
    ovr_d = ovr_q | (fm & ((state_q == OFFSET) |
                           ((state_q == OCC) & ~last)));
    if (fm) begin
      cnt_d = '0;
      idx_d = '0;
      act_d = 1'b0;
      if (eff_num != '0 && eff_off == '0) begin
        sfm_d = 1'b1;
        act_d = 1'b1;
      end
    end else if (qs) begin
      case (state_q)
        OFFSET: begin
          if (off_hit) begin
            cnt_d = '0;
            sfm_d = 1'b1;
            act_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        OCC: begin
          if (expiry) begin
            cnt_d = '0;
            if (last) begin
              act_d = 1'b0;
            end else begin
              idx_d = idx_q + 1'b1;
              sfm_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign format         = act_cfg.format;
  assign prach_cp       = act_cfg.prach_cp;
  assign wait_time      = act_cfg.wait_time;
  assign sub_frame_mrkr = sfm_q;
  assign occ_active     = act_q;
  assign occ_idx        = idx_q;
  assign frame_overrun  = ovr_q;

endmodule

// File: doc/jb_prach_occasion_sched.md
Name: jb_prach_occasion_sched

Overview:
- Scheduler and configuration controller in front of the PRACH FFT memory-write stage.
- Accepts PRACH occasion configuration over a valid/ready port and shadows it, then applies it atomically at frame boundaries.
- Counts qualified samples and generates the sub_frame_mrkr pulse train for each occasion. Holds format, prach_cp and wait_time stable to the write stage for the whole frame.

Parameters:
- CNT_W, 20, width of sample counters, offset and period.
- OCC_W, 4, width of occasion count and index.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- clk_en  in  1  clock enable; all state updates are qualified by it
- dv  in  1  input sample valid; a qualified sample is clk_en && dv
- frame_mrkr  in  1  frame start; sampled only on qualified samples; that sample is index 0
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  shadow register empty; transfer when cfg_valid && cfg_ready && clk_en
- cfg_format  in  4  PRACH format
- cfg_prach_cp  in  10  CP length code
- cfg_wait_time  in  CNT_W  wait time forwarded to the write stage
- cfg_offset  in  CNT_W  sample index of occasion 0 within the frame
- cfg_period  in  CNT_W  samples between occasion starts
- cfg_num_occ  in  OCC_W  occasions per frame; 0 disables
- format  out  4  active format
- prach_cp  out  10  active CP code
- wait_time  out  CNT_W  active wait time
- sub_frame_mrkr  out  1  occasion-start pulse
- occ_active  out  1  high from the first pulse until the last occasion's period expires
- occ_idx  out  OCC_W  index of the current occasion
- cfg_applied  out  1  pulse when the shadow is copied to active
- frame_overrun  out  1  sticky error flag

Behaviour:
- Reset values:
  - cfg_ready=1; every other output 0.
  - Active config 0 with num_occ=0; shadow empty.
  - State IDLE.
- Shadow register:
  - A transfer loads the shadow and sets full, so cfg_ready=0.
  - The shadow empties only on apply.
  - A new transfer while full is impossible because ready is low.
- Apply rule:
  - Happens on a qualified frame_mrkr when the shadow is full.
  - Copies the shadow to active and pulses cfg_applied for one clk_en cycle.
  - cfg_ready returns to 1 in the same update.
  - A frame_mrkr that applies new config uses the new offset, period and num_occ for that same frame.
- States and transitions:
  - IDLE → ARMED when the active or shadow config is valid, i.e. shadow full or active num_occ≠0.
  - ARMED waits for a qualified frame_mrkr, then applies the shadow if full.
    - If the effective num_occ=0, stay in ARMED.
    - Else clear cnt to 0 and go to OFFSET. If offset=0, take the OFFSET→OCC transition on this sample.
  - OFFSET counts qualified samples, cnt = sample index.
    - When the sample index equals offset: sub_frame_mrkr=1, occ_idx=0, occ_active=1, cnt=0, go to OCC.
  - OCC: cnt increments per qualified sample.
    - At cnt==period-1 with occ_idx<num_occ-1: wrap cnt to 0, occ_idx+1, pulse sub_frame_mrkr.
    - At cnt==period-1 with occ_idx==num_occ-1: occ_active=0, go to ARMED.
- Latency:
  - sub_frame_mrkr rises on the clk_en update of the qualified sample at index offset+k*period.
  - It is registered and lasts exactly one clk_en cycle.
  - Qualified samples carry no skip; without dv no counting occurs.
- Boundary conditions:
  - period=0 is treated as 1.
  - Counters saturate nowhere; width CNT_W, and cfg values are trusted to fit.
  - frame_mrkr while in OFFSET or OCC:
    - Set frame_overrun (sticky; cleared only by reset).
    - Abort the current occasion and process the frame as in ARMED, including apply and pulse at offset 0.
  - frame_mrkr and the final period expiry on the same sample: the frame_mrkr wins and follows the resync path, but frame_overrun is not set.
  - cfg transfer and apply on the same clk_en cycle with the shadow empty: the new config goes straight to active, cfg_applied pulses, and cfg_ready stays 1.
  - format, prach_cp and wait_time change only on apply.
- Reset mid-operation asynchronously returns every register to its reset value; the shadow is lost.

Decomposition:
- Package jb_prach_sched_pkg holds:
  - the state enum (IDLE, ARMED, OFFSET, OCC);
  - a cfg struct {format, prach_cp, wait_time, offset, period, num_occ};
  - the constant CNT_W_DEF=20.
- Sub-module jb_prach_cfg_shadow: valid/ready capture register with full flag and apply strobe. The FSM and counters stay in the top module.

Test Plan:
- Load cfg (fmt 0, cp 132, offset 10, period 100, num_occ 3), then frame_mrkr with dv continuous and clk_en=1 → cfg_applied at index 0; sub_frame_mrkr at samples 10, 110, 210; occ_active falls after sample 309; state ARMED.
- Same config with dv toggling 1/0 → pulses on the same qualified-sample indices (10, 110, 210), i.e. clock cycles 20, 220, 420; no counting on dv=0 cycles.
- Offset 0, period 1, num_occ 4 → pulses on 4 consecutive qualified samples starting at the frame_mrkr sample, then occ_active=0.
- Second cfg offered mid-frame (cp 64) → cfg_ready stays 0 until the next frame_mrkr; prach_cp switches 132→64 only at that marker.
- frame_mrkr at sample 150 of a running frame (offset 10, period 100, num_occ 3) → frame_overrun=1, occ_idx restarts 0, next pulse at new-frame sample 10.
- reset_n low during OCC → all outputs 0 and cfg_ready=1 immediately; a later frame_mrkr without new cfg produces no pulses.
